fetch_issue_pipelined: RTL
==========================

// Module: fetch_issue_pipelined
// PURPOSE
//  Next-gen fetch issue stage. Generates the sequential PC stream and issues I-cache reads with
//  a valid/ready handshake, keeping up to MAX_INFLIGHT reads outstanding. Records each issued PC
//  in an in-order tag FIFO so every returning response is paired with its PC for fetch receive.
//  A redirect (jump/branch/trap) squashes in-flight reads; their stale responses are dropped.
// PARAMETERS
//  CORE          0   core id, carried for debug only
//  ADDRESS_BITS  20  PC / address width
//  RESET_PC      0   PC loaded on reset
//  INSTR_BYTES   4   sequential increment; power of 2, >=1
//  WORD_SHIFT    2   i_mem_read_address = PC >> WORD_SHIFT
//  MAX_INFLIGHT  4   max outstanding reads (fresh + stale); power of 2, >=2
// PORTS
//  clock               in   1              rising-edge clock
//  reset               in   1              asynchronous, active-high
//  stall               in   1              hold: no new request; responses still accepted
//  redirect_valid      in   1              load redirect_PC, squash outstanding reads
//  redirect_PC         in   ADDRESS_BITS   new fetch target
//  i_mem_req_valid     out  1              read request valid
//  i_mem_req_ready     in   1              cache accepts request
//  i_mem_read_address  out  ADDRESS_BITS   PC_reg >> WORD_SHIFT
//  i_mem_rsp_valid     in   1              one in-order response; cannot be back-pressured
//  issue_valid         out  1              response is live; pass to fetch receive
//  issue_PC            out  ADDRESS_BITS   PC of the current response (FIFO head)
//  inflight_count      out  $clog2(MAX_INFLIGHT)+1  FIFO occupancy + drop_count
//  protocol_error      out  1              sticky: response arrived with nothing outstanding
// BEHAVIOUR
//  Reset (async): PC_reg=RESET_PC. FIFO empty. drop_count=0. protocol_error=0.
//   Hence req_valid=0, issue_valid=0, inflight_count=0.
//  req_valid = !reset & !stall & !redirect_valid & (inflight_count < MAX_INFLIGHT).
//   Comb; uses the registered count, so a same-cycle pop does not free a slot.
//  Request fire (valid&ready): push PC_reg to FIFO; PC_reg <= PC_reg+INSTR_BYTES, mod 2^ADDRESS_BITS.
//   The wrap from all-ones to 0 is legal.
//  req_valid held with !ready: PC_reg and address stay stable until ready.
//  Response with drop_count>0: drop_count-1; issue_valid=0.
//  Response with drop_count==0 and FIFO non-empty: pop; issue_valid=1, issue_PC=head, same cycle (comb).
//  Response with FIFO empty and drop_count==0: ignored; protocol_error<=1 until reset.
//  Redirect: PC_reg <= redirect_PC with low log2(INSTR_BYTES) bits cleared. FIFO flushed.
//   drop_count <= drop_count + FIFO count - (1 if a response arrives this cycle).
//   A response in the redirect cycle is also dropped: issue_valid=0.
//   No request issues in the redirect cycle; the new PC requests from the next cycle.
//  Redirect beats stall. Redirect while req_valid held: that request is withdrawn (legal, it never fired).
//  Simultaneous push and pop: FIFO count unchanged; full FIFO cannot be pushed (count gate).
//  Latency: redirect -> first request at new PC = 1 cycle; response -> issue_PC = 0 cycles.
// STRUCTURE
//  Shared package (fetch_pkg): INSTR_BYTES, WORD_SHIFT, RESET_PC defaults.
//   Also the legacy next_PC_select encoding constants (00 inc, 01 stall, 10 jump) for wrappers.
//  Sub-module fetch_pc_fifo: sync FIFO, DEPTH=MAX_INFLIGHT, WIDTH=ADDRESS_BITS.
//   Ports push/pop/flush, head, count; async reset; flush wins over push.
//  Top: PC_reg, drop_count, error flag, handshake logic.
// TESTING
//  Streaming: RESET_PC=0x100, ready=1, rsp 2 cycles after each req.
//   -> addrs 0x40,0x41,0x42...; issue_PC 0x100,0x104,0x108 in order.
//  Credit limit: ready=1, no rsp for 10 cycles -> exactly 4 fires.
//   req_valid=0, count=4; one rsp -> req_valid=1 the next cycle.
//  Redirect squash: 3 outstanding, redirect to 0x2002 plus a rsp in the same cycle.
//   -> drop_count=2; next 2 rsps issue_valid=0; first new request PC 0x2000.
//  Stall/backpressure: stall=1 with 2 outstanding -> no req, both rsps issued.
//   ready=0 for 3 cycles -> address held; PC advances only on fire.
//  Wrap/error: ADDRESS_BITS=8, PC=0xFC fire -> next PC 0x00.
//   rsp with nothing outstanding -> protocol_error=1 until async reset mid-stream clears all.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch definitions: default stage parameters, the legacy next-PC
// select encoding used by wrappers, and a small parameter-check helper.
package fetch_pkg;

  localparam int DEFAULT_INSTR_BYTES = 4;
  localparam int DEFAULT_WORD_SHIFT  = 2;
  localparam int DEFAULT_RESET_PC    = 0;

  // Legacy next_PC_select encoding; wrappers around older fetch units
  // still drive these values, so the codes are fixed.
  typedef enum logic [1:0] {
    NPC_INC   = 2'b00,
    NPC_STALL = 2'b01,
    NPC_JUMP  = 2'b10
  } next_pc_sel_e;

  // True when v is a positive power of two.
  function automatic logic is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/fetch_pc_fifo.sv
// In-order tag FIFO holding the PC of every issued, still-live I-cache read.
// The head is the PC that the next fresh response belongs to.
// Flush empties the FIFO and wins over a same-cycle push.
module fetch_pc_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 20
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  // A full FIFO only takes a push when an entry leaves the same cycle;
  // popping an empty FIFO is ignored.
  always_comb begin
    do_push = push && !flush && ((count < CW'(DEPTH)) || pop);
    do_pop  = pop && !flush && (count != '0);
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap freely.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_issue_pipelined.sv
// Fetch issue stage: walks the sequential PC stream, issues I-cache reads
// with a valid/ready handshake, and pairs each in-order response with the
// PC that requested it. Redirects squash outstanding reads; responses that
// belong to squashed reads are counted off and dropped.
//
// Handshake: a request transfers on a cycle where i_mem_req_valid and
// i_mem_req_ready are both high. While valid is high and ready is low the
// address stays stable; valid may only drop without a transfer when a
// redirect withdraws the request. Responses have no ready: one response
// per i_mem_rsp_valid cycle, in request order.
module fetch_issue_pipelined
  import fetch_pkg::*;
#(
  parameter int CORE         = 0,
  parameter int ADDRESS_BITS = 20,
  parameter int RESET_PC     = DEFAULT_RESET_PC,
  parameter int INSTR_BYTES  = DEFAULT_INSTR_BYTES,
  parameter int WORD_SHIFT   = DEFAULT_WORD_SHIFT,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            stall,
  input  logic                            redirect_valid,
  input  logic [ADDRESS_BITS-1:0]         redirect_PC,
  output logic                            i_mem_req_valid,
  input  logic                            i_mem_req_ready,
  output logic [ADDRESS_BITS-1:0]         i_mem_read_address,
  input  logic                            i_mem_rsp_valid,
  output logic                            issue_valid,
  output logic [ADDRESS_BITS-1:0]         issue_PC,
  output logic [$clog2(MAX_INFLIGHT):0]   inflight_count,
  output logic                            protocol_error
);

  localparam int CW = $clog2(MAX_INFLIGHT) + 1;
  localparam logic [ADDRESS_BITS-1:0] PC_INC     = ADDRESS_BITS'(INSTR_BYTES);
  localparam logic [ADDRESS_BITS-1:0] ALIGN_MASK = ~(ADDRESS_BITS'(INSTR_BYTES - 1));

  // CORE is carried for debug only; it takes part in the elaboration check.
  if (!is_pow2(INSTR_BYTES) || !is_pow2(MAX_INFLIGHT) || (MAX_INFLIGHT < 2) ||
      (CORE < 0) || (WORD_SHIFT < 0)) begin : g_bad_params
    $error("fetch_issue_pipelined: illegal parameter set");
  end

  logic [ADDRESS_BITS-1:0] pc_reg;
  logic [ADDRESS_BITS-1:0] pc_next;
  next_pc_sel_e            pc_sel;
  logic [CW-1:0]           drop_count;
  logic [CW-1:0]           drop_next;
  logic [CW-1:0]           fifo_count;
  logic [ADDRESS_BITS-1:0] fifo_head;
  logic                    req_fire;
  logic                    fifo_pop;
  logic                    rsp_consumed;
  logic                    rsp_orphan;

  // Request side: the credit check uses the registered occupancy, so a
  // response popping this cycle does not free a slot until the next one.
  always_comb begin
    inflight_count     = fifo_count + drop_count;
    i_mem_req_valid    = !reset && !stall && !redirect_valid &&
                         (inflight_count < CW'(MAX_INFLIGHT));
    i_mem_read_address = pc_reg >> WORD_SHIFT;
    req_fire           = i_mem_req_valid && i_mem_req_ready;
  end

  // Response side: stale responses burn drop credits first; a fresh one pops
  // the FIFO and issues with its PC in the same cycle. Any response that
  // finds nothing outstanding is an orphan and flags the protocol error.
  always_comb begin
    rsp_consumed = i_mem_rsp_valid && (inflight_count != '0);
    rsp_orphan   = i_mem_rsp_valid && (inflight_count == '0);
    fifo_pop     = i_mem_rsp_valid && !redirect_valid &&
                   (drop_count == '0) && (fifo_count != '0);
    issue_valid  = fifo_pop;
    issue_PC     = fifo_head;
  end

  // Drop credits: a redirect turns every FIFO entry into a credit, minus the
  // one consumed by a response arriving in the redirect cycle itself.
  always_comb begin
    drop_next = drop_count;
    if (redirect_valid) begin
      drop_next = drop_count + fifo_count - CW'(rsp_consumed);
    end else if (i_mem_rsp_valid && (drop_count != '0)) begin
      drop_next = drop_count - 1'b1;
    end
  end

  // Next-PC select: redirect beats a fire; otherwise the PC holds.
  always_comb begin
    pc_sel  = NPC_STALL;
    pc_next = pc_reg;
    if (redirect_valid) begin
      pc_sel = NPC_JUMP;
    end else if (req_fire) begin
      pc_sel = NPC_INC;
    end
    case (pc_sel)
      NPC_JUMP: pc_next = redirect_PC & ALIGN_MASK;
      NPC_INC:  pc_next = pc_reg + PC_INC;
      default:  pc_next = pc_reg;
    endcase
  end

  // PC, drop credits and the sticky error flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_reg         <= ADDRESS_BITS'(RESET_PC);
      drop_count     <= '0;
      protocol_error <= 1'b0;
    end else begin
      pc_reg     <= pc_next;
      drop_count <= drop_next;
      if (rsp_orphan) begin
        protocol_error <= 1'b1;
      end
    end
  end

  fetch_pc_fifo #(
    .DEPTH (MAX_INFLIGHT),
    .WIDTH (ADDRESS_BITS)
  ) u_pc_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (req_fire),
    .push_data (pc_reg),
    .pop       (fifo_pop),
    .flush     (redirect_valid),
    .head      (fifo_head),
    .count     (fifo_count)
  );

endmodule
